host_seq: RTL and testbench

HOST_SEQ -- requirements
Module: host_seq

---
 rtl/host_seq.sv | 173 +++++++++++++++++
 tb/tb_host_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_seq.sv
// Host-side test sequencer: loads operands into a DUT's data memory, resets and starts it,
// waits for done (with timeout), reads the results back against expected bytes and reports.
module host_seq #(
   parameter int          N_LOAD    = 4,
   parameter logic [7:0]  LOAD_BASE = 8'd0,
   parameter int          N_READ    = 4,
   parameter logic [7:0]  RES_BASE  = 8'd0,
   parameter logic [11:0] TIMEOUT   = 12'd2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic [7:0]  ld_data,
   input  logic [7:0]  exp_data,
   input  logic        dut_done,
   input  logic [7:0]  mem_rdata,
   output logic        dut_reset,
   output logic        dut_start,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic        tmo,
   output logic [11:0] cycles
);

   typedef enum logic [2:0] {
      IDLE, LOAD, DRST, START, RUN, READ, REPORT
   } state_t;

   localparam logic [6:0] LOAD_LAST = 7'(N_LOAD - 1);
   localparam logic [6:0] READ_LAST = 7'(N_READ - 1);

   state_t      state_q, state_d;
   logic [6:0]  idx_q, idx_d;
   logic [11:0] cycles_q, cycles_d;
   logic        err_q, err_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic        tmo_q, tmo_d;
   logic        mem_we_q, dut_reset_q, dut_start_q, busy_q;
   logic [7:0]  mem_addr_q, mem_addr_d;
   logic        errNow;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cycles_d = cycles_q;
      err_d    = err_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      tmo_d    = tmo_q;
      errNow   = err_q | (mem_rdata != exp_data);

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d  = LOAD;
               idx_d    = 7'd0;
               cycles_d = 12'd0;
               err_d    = 1'b0;
               pass_d   = 1'b0;
               fail_d   = 1'b0;
               tmo_d    = 1'b0;
            end
         end
         LOAD: begin
            if (idx_q == LOAD_LAST) begin
               state_d = DRST;
               idx_d   = 7'd0;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         DRST: begin
            state_d = START;
            idx_d   = 7'd0;
         end
         // idx doubles as the two-cycle start-pulse counter
         START: begin
            if (idx_q == 7'd1) begin
               state_d = RUN;
               idx_d   = 7'd0;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         // done is checked before the timeout so a coincident done still reads back
         RUN: begin
            cycles_d = (cycles_q == 12'hFFF) ? cycles_q : cycles_q + 12'd1;
            if (dut_done) begin
               state_d = READ;
               idx_d   = 7'd0;
            end else if (cycles_d == TIMEOUT) begin
               state_d = REPORT;
               tmo_d   = 1'b1;
            end
         end
         READ: begin
            err_d = errNow;
            if (idx_q == READ_LAST) begin
               state_d = REPORT;
               idx_d   = 7'd0;
               pass_d  = ~errNow;
               fail_d  = errNow;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      mem_addr_d = 8'd0;
      if (state_d == LOAD) begin
         mem_addr_d = LOAD_BASE + {1'b0, idx_d};
      end else if (state_d == READ) begin
         mem_addr_d = RES_BASE + {1'b0, idx_d};
      end
   end

   // Strobes and address are registered from the next state so they line up with the state they belong to
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 7'd0;
         cycles_q    <= 12'd0;
         err_q       <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         tmo_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 8'd0;
         dut_reset_q <= 1'b0;
         dut_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cycles_q    <= cycles_d;
         err_q       <= err_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         tmo_q       <= tmo_d;
         mem_we_q    <= (state_d == LOAD);
         mem_addr_q  <= mem_addr_d;
         dut_reset_q <= (state_d == DRST);
         dut_start_q <= (state_d == START);
         busy_q      <= (state_d != IDLE);
      end
   end

   // Operand byte tracks mem_addr through the host's lookup, so it is gated rather than re-registered
   assign mem_wdata = mem_we_q ? ld_data : 8'd0;
   assign dut_reset = reset | dut_reset_q;
   assign dut_start = dut_start_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign busy      = busy_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign tmo       = tmo_q;
   assign cycles    = cycles_q;

endmodule

// File: tb/tb_host_seq.sv
// Scoreboard bench for host_seq: two instances (default and LOAD_BASE=FE) each driving a small
// behavioural DUT model; stimulus queues expected run records, per-instance monitors check them.
module tb_host_seq;

   typedef struct {
      int id;
      int expPass;
      int expFail;
      int expTmo;
      int expCycles;
      int expBusy;
   } runRec_t;

   logic       clk;
   logic       reset;
   logic       clearMem;
   logic       goReq   [2];
   logic       corrupt [2];
   int         doneAt  [2];
   logic [7:0] opTab   [4];
   logic [7:0] expTab  [2][4];

   runRec_t runQ[$];
   int      checks;
   int      passes;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int expv);
      checks++;
      if (act == expv) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam logic [7:0] LB = (g == 0) ? 8'h00 : 8'hFE;

      logic        memWe, dutReset, dutStart, busy, pass, fail, tmo, dutDone;
      logic [7:0]  memAddr, memWdata, ldData, expData, memRdata, ldOff;
      logic [11:0] cycles;
      logic [7:0]  mem [256];

      host_seq #(.LOAD_BASE(LB)) dut (
         .clk(clk), .reset(reset), .go(goReq[g]), .ld_data(ldData), .exp_data(expData),
         .dut_done(dutDone), .mem_rdata(memRdata), .dut_reset(dutReset), .dut_start(dutStart),
         .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .busy(busy),
         .pass(pass), .fail(fail), .tmo(tmo), .cycles(cycles)
      );

      // Host-side operand and expected-result lookup, indexed by the current address
      assign ldOff    = memAddr - LB;
      assign ldData   = (ldOff < 8'd4) ? opTab[ldOff[1:0]] : 8'h00;
      assign expData  = (memAddr < 8'd4) ? expTab[g][memAddr[1:0]] : 8'h00;
      assign memRdata = mem[memAddr] ^ ((corrupt[g] && memAddr == 8'd2) ? 8'h01 : 8'h00);

      always @(posedge clk) begin
         if (clearMem) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
         end else if (memWe) begin
            mem[memAddr] <= memWdata;
         end
      end

      // DUT model: counts cycles from the start fall and raises done on cycle doneAt
      int   cnt;
      logic armed, prevStart;
      initial begin
         cnt = 0; armed = 1'b0; prevStart = 1'b0; dutDone = 1'b0;
      end
      always @(negedge clk) begin
         if (dutReset) begin
            armed = 1'b0;
            cnt   = 0;
         end else if (prevStart && !dutStart) begin
            armed = 1'b1;
            cnt   = 1;
         end else if (armed) begin
            cnt++;
         end
         prevStart = dutStart;
         dutDone   = armed && (doneAt[g] != 0) && (cnt == doneAt[g]);
      end

      // Monitor: accumulate a run while busy, compare against the queued record when busy drops
      int      wIdx, busyCnt, rstCnt, stCnt;
      logic    inRun;
      runRec_t rec;
      initial begin
         wIdx = 0; busyCnt = 0; rstCnt = 0; stCnt = 0; inRun = 1'b0;
      end
      always @(negedge clk) begin
         if (reset) begin
            wIdx = 0; busyCnt = 0; rstCnt = 0; stCnt = 0; inRun = 1'b0;
         end else if (busy) begin
            inRun = 1'b1;
            busyCnt++;
            if (memWe) begin
               checkOutput("wr_addr", int'(memAddr), int'(8'(LB + 8'(wIdx))));
               checkOutput("wr_data", int'(memWdata), int'(opTab[wIdx % 4]));
               wIdx++;
            end
            if (dutReset) rstCnt++;
            if (dutStart) stCnt++;
         end else if (inRun) begin
            if (runQ.size() == 0) begin
               checkOutput("unexpected_run", g, -1);
            end else begin
               rec = runQ.pop_front();
               checkOutput("run_id", g, rec.id);
               checkOutput("pass", int'(pass), rec.expPass);
               checkOutput("fail", int'(fail), rec.expFail);
               checkOutput("tmo", int'(tmo), rec.expTmo);
               checkOutput("cycles", int'(cycles), rec.expCycles);
               checkOutput("busy_cycles", busyCnt, rec.expBusy);
               checkOutput("write_count", wIdx, 4);
               checkOutput("dut_reset_len", rstCnt, 1);
               checkOutput("dut_start_len", stCnt, 2);
            end
            wIdx = 0; busyCnt = 0; rstCnt = 0; stCnt = 0; inRun = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input int id);
      @(negedge clk);
      goReq[id] = 1'b1;
      @(negedge clk);
      goReq[id] = 1'b0;
   endtask

   task automatic expectRun(input int id, input int p, input int f, input int t, input int cyc, input int bc);
      runRec_t r;
      r.id = id; r.expPass = p; r.expFail = f; r.expTmo = t; r.expCycles = cyc; r.expBusy = bc;
      runQ.push_back(r);
   endtask

   task automatic waitIdle(input int id);
      int n;
      n = 0;
      while ((id == 0 ? gi[0].busy : gi[1].busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) checkOutput("idle_timeout", n, 0);
      @(negedge clk);
   endtask

   initial begin
      checks = 0; passes = 0;
      opTab[0] = 8'h3C; opTab[1] = 8'hA5; opTab[2] = 8'h5A; opTab[3] = 8'hC3;
      expTab[0][0] = 8'h3C; expTab[0][1] = 8'hA5; expTab[0][2] = 8'h5A; expTab[0][3] = 8'hC3;
      expTab[1][0] = 8'h5A; expTab[1][1] = 8'hC3; expTab[1][2] = 8'h00; expTab[1][3] = 8'h00;
      goReq[0] = 1'b0; goReq[1] = 1'b0;
      corrupt[0] = 1'b0; corrupt[1] = 1'b0;
      doneAt[0] = 10; doneAt[1] = 10;
      reset = 1'b1; clearMem = 1'b1;
      repeat (3) @(negedge clk);
      clearMem = 1'b0;

      checkOutput("rst_busy", int'(gi[0].busy), 0);
      checkOutput("rst_pass", int'(gi[0].pass), 0);
      checkOutput("rst_fail", int'(gi[0].fail), 0);
      checkOutput("rst_tmo", int'(gi[0].tmo), 0);
      checkOutput("rst_cycles", int'(gi[0].cycles), 0);
      checkOutput("rst_mem_we", int'(gi[0].memWe), 0);
      checkOutput("rst_mem_addr", int'(gi[0].memAddr), 0);
      checkOutput("rst_dut_start", int'(gi[0].dutStart), 0);
      checkOutput("rst_dut_reset_held", int'(gi[0].dutReset), 1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("dut_reset_released", int'(gi[0].dutReset), 0);

      $display("[TB] basic run, done after 10 cycles");
      expectRun(0, 1, 0, 0, 10, 22);
      applyStimulus(0);
      waitIdle(0);

      $display("[TB] corrupted result byte 2");
      corrupt[0] = 1'b1;
      expectRun(0, 0, 1, 0, 10, 22);
      applyStimulus(0);
      waitIdle(0);
      corrupt[0] = 1'b0;

      $display("[TB] done never asserted");
      doneAt[0] = 0;
      expectRun(0, 0, 0, 1, 2000, 2008);
      applyStimulus(0);
      waitIdle(0);

      $display("[TB] done on the timeout cycle");
      doneAt[0] = 2000;
      expectRun(0, 1, 0, 0, 2000, 2012);
      applyStimulus(0);
      waitIdle(0);
      doneAt[0] = 10;

      $display("[TB] reset during LOAD");
      applyStimulus(0);
      @(negedge clk);
      checkOutput("mid_load_addr", int'(gi[0].memAddr), 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", int'(gi[0].busy), 0);
      checkOutput("abort_mem_we", int'(gi[0].memWe), 0);
      checkOutput("abort_mem_addr", int'(gi[0].memAddr), 0);
      checkOutput("abort_mem_wdata", int'(gi[0].memWdata), 0);
      checkOutput("abort_dut_reset", int'(gi[0].dutReset), 1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_dut_reset_rel", int'(gi[0].dutReset), 0);
      expectRun(0, 1, 0, 0, 10, 22);
      applyStimulus(0);
      waitIdle(0);

      $display("[TB] wrapping load base, go during RUN");
      expectRun(1, 1, 0, 0, 10, 22);
      applyStimulus(1);
      repeat (10) @(negedge clk);
      goReq[1] = 1'b1;
      @(negedge clk);
      goReq[1] = 1'b0;
      waitIdle(1);
      repeat (30) @(negedge clk);
      checkOutput("go_not_queued_busy", int'(gi[1].busy), 0);
      checkOutput("scoreboard_empty", runQ.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
